// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between N_REQ requesters.
// Round-robin grant, valid/ready request and response handshakes,
// registered ALU operands and registered result/flag capture.
// Optional macro ALU_SHARE_STICKY_EN adds per-requester sticky overflow
// status (sticky_of) with a per-requester clear (sticky_clr).
module alu_share_ctrl #(
    parameter int W      = 4,
    parameter int N_REQ  = 2,
    parameter int MAX_OP = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ*4-1:0] req_sel,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [W-1:0]       rsp_result,
    output logic [3:0]         rsp_flags,
    output logic               rsp_err,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    output logic [3:0]         alu_sel,
    input  logic [W-1:0]       alu_result,
    input  logic               alu_of,
    input  logic               alu_carry,
    input  logic               alu_cero,
    input  logic               alu_neg,
`ifdef ALU_SHARE_STICKY_EN
    output logic [N_REQ-1:0]   sticky_of,
    input  logic [N_REQ-1:0]   sticky_clr,
`endif
    output logic               busy
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] cur;
    logic [GW-1:0] gnt;
    logic          found;
    logic [W-1:0]  gnt_a;
    logic [W-1:0]  gnt_b;
    logic [3:0]    gnt_sel;
    logic          gnt_legal;
    logic          rsp_hs;

    // Round-robin search: first valid requester after last_grant, wrapping
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            logic [GW-1:0] idx;
            idx = GW'((32'(last_grant) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    // Operands and op select of the granted requester
    always_comb begin
        gnt_a     = req_a[32'(gnt)*W +: W];
        gnt_b     = req_b[32'(gnt)*W +: W];
        gnt_sel   = req_sel[32'(gnt)*4 +: 4];
        gnt_legal = (32'(gnt_sel) <= MAX_OP);
    end

    // Request accept only in IDLE, one-hot on the granted requester
    always_comb begin
        req_ready = '0;
        if (state == IDLE && found)
            req_ready[gnt] = 1'b1;
    end

    // Response valid only in RESP, one-hot on the owner of the current op
    always_comb begin
        rsp_valid = '0;
        if (state == RESP)
            rsp_valid[cur] = 1'b1;
    end

    assign busy   = (state != IDLE);
    assign rsp_hs = (state == RESP) && rsp_ready[cur];

    // Controller FSM with operand latch and result/flag capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GW'(N_REQ - 1);
            cur        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cur <= gnt;
                        if (gnt_legal) begin
                            alu_a   <= gnt_a;
                            alu_b   <= gnt_b;
                            alu_sel <= gnt_sel;
                            state   <= EXEC;
                        end else begin
                            // Illegal select bypasses the ALU; alu_* keep old values
                            rsp_result <= '0;
                            rsp_flags  <= '0;
                            rsp_err    <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= {alu_of, alu_carry, alu_cero, alu_neg};
                    rsp_err    <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        last_grant <= cur;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SHARE_STICKY_EN
    logic [N_REQ-1:0] sticky_set;

    // Overflow seen on a completed response for the owning requester
    always_comb begin
        sticky_set = '0;
        if (rsp_hs && rsp_flags[3])
            sticky_set[cur] = 1'b1;
    end

    // Sticky overflow status; set takes priority over clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_of <= '0;
        else
            sticky_of <= (sticky_of & ~sticky_clr) | sticky_set;
    end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a stub ALU and a
// transaction-level reference model. Honours ALU_SHARE_STICKY_EN.
`timescale 1ns/1ps
module tb_alu_share_ctrl;
    localparam int W = 4;
    localparam int N = 2;
    localparam int MAXOP = 9;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [N*4-1:0] req_sel;
    logic [W-1:0]   rsp_result, alu_a, alu_b, alu_result;
    logic [3:0]     rsp_flags, alu_sel;
    logic           rsp_err, busy, alu_of, alu_carry, alu_cero, alu_neg;
`ifdef ALU_SHARE_STICKY_EN
    logic [N-1:0]   sticky_of, sticky_clr;
`endif

    int n_checks = 0;
    int n_fail = 0;
    logic [N-1:0] seen_ready = '0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.W(W), .N_REQ(N), .MAX_OP(MAXOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_of(alu_of), .alu_carry(alu_carry),
        .alu_cero(alu_cero), .alu_neg(alu_neg),
`ifdef ALU_SHARE_STICKY_EN
        .sticky_of(sticky_of), .sticky_clr(sticky_clr),
`endif
        .busy(busy)
    );

    // Stub ALU: returns {of, carry, cero, neg, result}
    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] sel);
        logic [4:0] s;
        logic [3:0] r;
        logic c, v;
        c = 1'b0; v = 1'b0; r = '0;
        case (sel)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                        v = (a[3] == b[3]) && (r[3] != a[3]); end
            4'd1: begin r = a - b; c = (a < b); v = (a[3] != b[3]) && (r[3] != a[3]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
            4'd7: begin r = {1'b0, a[3:1]}; c = a[0]; end
            4'd8: begin r = a + 4'd1; c = (a == 4'hF); v = (a == 4'h7); end
            default: begin r = a - 4'd1; c = (a == 4'h0); v = (a == 4'h8); end
        endcase
        return {v, c, (r == 4'h0), r[3], r};
    endfunction

    always_comb {alu_of, alu_carry, alu_cero, alu_neg, alu_result} = alu_fn(alu_a, alu_b, alu_sel);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Reference model: one outstanding transaction, round-robin pointer
    bit           m_busy;
    int           m_owner, m_wait, m_last;
    logic [3:0]   m_res, m_flg, m_a, m_b, m_sel;
    logic         m_err;
    logic [N-1:0] m_sticky;

    // Compare process: check every cycle, then advance the model
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy, exp_vld, sset;
        logic [7:0]   r;
        logic [3:0]   sa, sb, ss;
        int g;
        seen_ready = req_ready;
        if (!rst_n) begin
            m_busy = 0; m_last = N - 1; m_owner = 0; m_wait = 0;
            m_a = 0; m_b = 0; m_sel = 0; m_res = 0; m_flg = 0; m_err = 0; m_sticky = '0;
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_alu_sel", 32'(alu_sel), 0);
        end else begin
            g = m_busy ? -1 : pick(req_valid, m_last);
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            exp_vld = '0;
            if (m_busy && m_wait == 0) exp_vld[m_owner] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
            chk("alu_sel", 32'(alu_sel), 32'(m_sel));
            if (exp_vld != '0) begin
                chk("rsp_result", 32'(rsp_result), 32'(m_res));
                chk("rsp_flags", 32'(rsp_flags), 32'(m_flg));
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
            sset = '0;
`ifdef ALU_SHARE_STICKY_EN
            chk("sticky_of", 32'(sticky_of), 32'(m_sticky));
`endif
            if (m_busy) begin
                if (m_wait > 0) m_wait--;
                else if (rsp_ready[m_owner]) begin
                    if (m_flg[3]) sset[m_owner] = 1'b1;
                    m_busy = 0;
                    m_last = m_owner;
                end
            end else if (g >= 0) begin
                sa = req_a[g*W +: W]; sb = req_b[g*W +: W]; ss = req_sel[g*4 +: 4];
                m_busy = 1; m_owner = g;
                if (ss <= MAXOP) begin
                    m_a = sa; m_b = sb; m_sel = ss; m_wait = 1;
                    r = alu_fn(sa, sb, ss);
                    m_flg = r[7:4]; m_res = r[3:0]; m_err = 0;
                end else begin
                    m_wait = 0; m_res = 0; m_flg = 0; m_err = 1;
                end
            end
`ifdef ALU_SHARE_STICKY_EN
            m_sticky = (m_sticky & ~sticky_clr) | sset;
`endif
        end
    end

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] s);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_sel[i*4 +: 4] = s;
        req_valid[i] = 1'b1;
    endtask

    // Waits for accept of requester i; returns at 1ns after the accept edge
    task automatic wait_accept(input int i);
        bit ok;
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1;
            @(posedge clk); #1;
        end
        chk("accept_in_time", 32'(ok), 1);
        req_valid[i] = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int grants[4];
        int n_g, excl;
        req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = '0;
`ifdef ALU_SHARE_STICKY_EN
        sticky_clr = '0;
`endif
        #12;
        chk("reset_result", 32'(rsp_result), 0);
        chk("reset_flags", 32'(rsp_flags), 0);
        chk("reset_err", 32'(rsp_err), 0);
        chk("reset_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single legal op: 6 & 3
        set_req(0, 4'h6, 4'h3, 4'd2);
        wait_accept(0);
        chk("op_exec_no_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        chk("op_rsp_valid", 32'(rsp_valid), 32'b01);
        chk("op_result", 32'(rsp_result), 32'h2);
        chk("op_flags", 32'(rsp_flags), 0);
        chk("op_err", 32'(rsp_err), 0);
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        rsp_ready = '0;

        // Round robin from reset with both requesters always valid
        reset_pulse();
        rsp_ready = 2'b11;
        set_req(0, 4'h5, 4'hA, 4'd3);
        set_req(1, 4'h9, 4'h3, 4'd4);
        n_g = 0; excl = 0;
        for (int c = 0; c < 40 && n_g < 4; c++) begin
            @(negedge clk);
            if (req_ready == 2'b11) excl++;
            if (req_ready != '0) begin
                grants[n_g] = req_ready[1] ? 1 : 0;
                n_g++;
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        chk("rr_count", 32'(n_g), 4);
        chk("rr_grant0", 32'(grants[0]), 0);
        chk("rr_grant1", 32'(grants[1]), 1);
        chk("rr_grant2", 32'(grants[2]), 0);
        chk("rr_grant3", 32'(grants[3]), 1);
        chk("rr_exclusive", 32'(excl), 0);
        repeat (4) @(posedge clk);
        #1 rsp_ready = '0;

        // Illegal op on requester 1: responds next cycle, alu_sel keeps 4
        set_req(1, 4'h5, 4'h5, 4'b1100);
        wait_accept(1);
        chk("ill_rsp_valid", 32'(rsp_valid), 32'b10);
        chk("ill_result", 32'(rsp_result), 0);
        chk("ill_flags", 32'(rsp_flags), 0);
        chk("ill_err", 32'(rsp_err), 1);
        chk("ill_alu_sel", 32'(alu_sel), 4);
        rsp_ready = 2'b10;
        @(posedge clk); #1;
        rsp_ready = '0;

        // Response backpressure: 7 + 9 held for 5 cycles
        set_req(0, 4'h7, 4'h9, 4'd0);
        wait_accept(0);
        @(posedge clk); #1;
        set_req(1, 4'h1, 4'h2, 4'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_busy", 32'(busy), 1);
            chk("bp_valid", 32'(rsp_valid), 32'b01);
            chk("bp_result", 32'(rsp_result), 0);
            chk("bp_flags", 32'(rsp_flags), 32'b0110);
            chk("bp_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        chk("bp_idle", 32'(busy), 0);
        chk("bp_next_grant", 32'(req_ready), 32'b10);
        rsp_ready = 2'b11;
        wait_accept(1);
        repeat (3) @(posedge clk);
        #1 rsp_ready = '0;

        // Async reset while in EXEC drops the op
        set_req(0, 4'h3, 4'h4, 4'd3);
        wait_accept(0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(rsp_valid), 0);
        chk("arst_alu_sel", 32'(alu_sel), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("arst_no_rsp", 32'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        rsp_ready = '0;

`ifdef ALU_SHARE_STICKY_EN
        // Sticky overflow: 7 + 1 overflows
        rsp_ready = 2'b10;
        set_req(1, 4'h7, 4'h1, 4'd0);
        wait_accept(1);
        @(posedge clk);
        @(posedge clk); #1;
        chk("sticky_set", 32'(sticky_of), 32'b10);
        rsp_ready = '0;
        sticky_clr = 2'b10;
        @(posedge clk); #1;
        sticky_clr = '0;
        chk("sticky_clr", 32'(sticky_of), 0);
        set_req(1, 4'h7, 4'h1, 4'd0);
        wait_accept(1);
        @(posedge clk); #1;
        rsp_ready = 2'b10;
        sticky_clr = 2'b10;
        @(posedge clk); #1;
        chk("sticky_set_wins", 32'(sticky_of), 32'b10);
        sticky_clr = '0;
        rsp_ready = '0;
`endif

        // Randomised traffic checked by the model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && seen_ready[i]) begin
                    set_req(i, 4'($urandom), 4'($urandom), 4'($urandom));
                    req_valid[i] = ($urandom % 3) != 0;
                end else if (req_valid[i]) begin
                    if ($urandom % 16 == 0) req_valid[i] = 1'b0;
                end else if ($urandom % 2 == 1) begin
                    set_req(i, 4'($urandom), 4'($urandom), 4'($urandom));
                end
                rsp_ready[i] = ($urandom % 4) != 0;
`ifdef ALU_SHARE_STICKY_EN
                sticky_clr[i] = ($urandom % 8) == 0;
`endif
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        rsp_ready = 2'b11;
        repeat (6) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
